alu_shift_seq: RTL

- Multi-cycle shift sequencer that acts as the initiator on the alu interface (in1/in2/op in, out/zero/negative back).
- The alu shifts by exactly 1 per operation. This block runs an LC-3b shift by a 4-bit amount (0-15) as repeated single-bit alu shifts.
- After the last shift it makes one pass-through alu operation to capture the final N/Z/P condition codes.
- It sits between the datapath control FSM and the alu instance.

---
 rtl/alu_shift_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/alu_shift_seq.sv
// Multi-cycle shift sequencer: drives an external single-bit-shift alu repeatedly,
// then makes one pass-through alu op to capture N/Z/P condition codes.
module alu_shift_seq #(
  parameter int         WIDTH   = 16,
  parameter logic [2:0] OP_ADD  = 3'd0,
  parameter logic [2:0] OP_LSHF = 3'd4,
  parameter logic [2:0] OP_RSHF = 3'd5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic [3:0]       amount,
  input  logic             dir,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       nzp,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_negative
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLAG  = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] acc_r;
  logic [3:0]       cnt_r;
  logic             dir_r;

  function automatic logic [2:0] calc_nzp(input logic neg, input logic zero);
    return {neg, zero, ~neg & ~zero};
  endfunction

  assign busy = (state_r != IDLE);

  // Sequencer state, shift accumulator and registered result/flags/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= {WIDTH{1'b0}};
      cnt_r   <= 4'd0;
      dir_r   <= 1'b0;
      result  <= {WIDTH{1'b0}};
      nzp     <= 3'b000;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r   <= value;
            cnt_r   <= amount;
            dir_r   <= dir;
            // A zero shift skips straight to the flag pass.
            state_r <= (amount != 4'd0) ? SHIFT : FLAG;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          acc_r   <= alu_out;
          cnt_r   <= cnt_r - 4'd1;
          state_r <= (cnt_r == 4'd1) ? FLAG : SHIFT;
        end
        FLAG: begin
          result  <= alu_out;
          nzp     <= calc_nzp(alu_negative, alu_zero);
          done    <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // alu operand/op selection follows the current state.
  always_comb begin
    alu_in1 = {WIDTH{1'b0}};
    alu_in2 = {WIDTH{1'b0}};
    alu_op  = OP_ADD;
    case (state_r)
      IDLE: begin
        alu_in1 = {WIDTH{1'b0}};
        alu_op  = OP_ADD;
      end
      SHIFT: begin
        alu_in1 = acc_r;
        alu_op  = dir_r ? OP_RSHF : OP_LSHF;
      end
      FLAG: begin
        alu_in1 = acc_r;
        alu_op  = OP_ADD;
      end
      default: begin
        alu_in1 = {WIDTH{1'b0}};
        alu_op  = OP_ADD;
      end
    endcase
  end

endmodule
